// File: rtl/cnn_axi_wr_slave.sv
// cnn_axi_wr_slave
//   AXI3-style write-path slave (AW/W/B) that turns bursts into single-port
//   memory write strobes for the weight/config buffers in cnn_top.
//   One burst is outstanding at a time. FIXED, INCR and WRAP bursts are
//   supported; protocol violations give SLVERR and suppress the offending
//   and all later beats of that burst.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   awid/awaddr/awlen/awsize/awbrust/awvalid/awready   write address channel
//   wid/wdata/wstrb/wlast/wvalid/wready                 write data channel
//   bid/bresp/buser/bvalid/bready                       write response channel
//   mem_we/mem_addr/mem_wdata/mem_wstrb                 registered memory write port
module cnn_axi_wr_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_MAX_WIDTH = 12,
    parameter int MEM_AW       = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ID_MAX_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [3:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awbrust,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ID_MAX_WIDTH-1:0]   wid,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [ID_MAX_WIDTH-1:0]   bid,
    output logic [1:0]                bresp,
    output logic                      buser,
    output logic                      bvalid,
    input  logic                      bready,
    output logic                      mem_we,
    output logic [MEM_AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int B      = $clog2(STRB_W);
    localparam int WA_HI  = MEM_AW + B;   // first byte-address bit above the memory

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                    state_reg, state_next;
    logic                      awready_reg, awready_next;
    logic [ID_MAX_WIDTH-1:0]   id_reg, id_next;
    logic [MEM_AW-1:0]         addr_reg, addr_next;
    logic [3:0]                len_reg, len_next;
    logic [1:0]                burst_reg, burst_next;
    logic [4:0]                beat_cnt_reg, beat_cnt_next;
    logic                      err_reg, err_next;
    logic                      mem_we_reg, mem_we_next;
    logic [MEM_AW-1:0]         mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0]     mem_wdata_reg, mem_wdata_next;
    logic [STRB_W-1:0]         mem_wstrb_reg, mem_wstrb_next;

    // Address-channel checks; the slices depend on parameters, so guard them.
    logic addr_lo_err, addr_hi_err, aw_err;

    generate
        if (B > 0) begin : g_lo
            assign addr_lo_err = |awaddr[(B > 0 ? B-1 : 0):0];
        end else begin : g_no_lo
            assign addr_lo_err = 1'b0;
        end
        if (WA_HI < ADDR_WIDTH) begin : g_hi
            assign addr_hi_err = |awaddr[ADDR_WIDTH-1:(WA_HI < ADDR_WIDTH ? WA_HI : 0)];
        end else begin : g_no_hi
            assign addr_hi_err = 1'b0;
        end
    endgenerate

    assign aw_err = (awsize != 3'(B))
                  | (awbrust == 2'b11)
                  | addr_hi_err
                  | addr_lo_err
                  | ((awbrust == 2'b10) && !(awlen inside {4'd1, 4'd3, 4'd7, 4'd15}));

    // Beat-level checks
    logic aw_hs, w_hs, last_match, beat_err, err_now, do_write;
    logic [MEM_AW-1:0] addr_inc, wrap_mask;

    assign aw_hs      = awvalid & awready_reg;
    assign w_hs       = wvalid & wready;
    assign last_match = (beat_cnt_reg == {1'b0, len_reg});
    assign beat_err   = (wid != id_reg) | (wlast != last_match);
    assign err_now    = err_reg | beat_err;
    // A beat that itself raises the error is already suppressed.
    assign do_write   = w_hs & ~err_now & (beat_cnt_reg <= {1'b0, len_reg});
    assign addr_inc   = addr_reg + 1'b1;
    assign wrap_mask  = MEM_AW'(len_reg);

    always_comb begin
        state_next     = state_reg;
        id_next        = id_reg;
        addr_next      = addr_reg;
        len_next       = len_reg;
        burst_next     = burst_reg;
        beat_cnt_next  = beat_cnt_reg;
        err_next       = err_reg;
        mem_we_next    = do_write;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;

        case (state_reg)
            IDLE: begin
                if (aw_hs) begin
                    id_next       = awid;
                    addr_next     = awaddr[WA_HI-1:B];
                    len_next      = awlen;
                    burst_next    = awbrust;
                    beat_cnt_next = '0;
                    err_next      = aw_err;
                    state_next    = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    err_next      = err_now;
                    // Saturate so a runaway burst never aliases back to beat 0.
                    beat_cnt_next = (&beat_cnt_reg) ? beat_cnt_reg : beat_cnt_reg + 5'd1;
                    case (burst_reg)
                        2'b01:   addr_next = addr_inc;
                        2'b10:   addr_next = (addr_reg & ~wrap_mask) | (addr_inc & wrap_mask);
                        default: addr_next = addr_reg;
                    endcase
                    if (wlast) begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (do_write) begin
            mem_addr_next  = addr_reg;
            mem_wdata_next = wdata;
            mem_wstrb_next = wstrb;
        end
    end

    // awready is registered: it follows the state we are about to enter.
    assign awready_next = (state_next == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            awready_reg   <= 1'b0;
            id_reg        <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            burst_reg     <= '0;
            beat_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
        end else begin
            state_reg     <= state_next;
            awready_reg   <= awready_next;
            id_reg        <= id_next;
            addr_reg      <= addr_next;
            len_reg       <= len_next;
            burst_reg     <= burst_next;
            beat_cnt_reg  <= beat_cnt_next;
            err_reg       <= err_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
        end
    end

    assign awready   = awready_reg;
    assign wready    = (state_reg == DATA);
    assign bvalid    = (state_reg == RESP);
    assign bid       = bvalid ? id_reg : '0;
    assign bresp     = (bvalid && err_reg) ? 2'b10 : 2'b00;
    assign buser     = 1'b0;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;

endmodule
